mips_retire_monitor: RTL and testbench

- Synthesizable retirement monitor for the MIPS cores (single-cycle now, pipelined next); replaces ad-hoc $display tracing with on-chip state.
- Classifies each retired instruction (ADD/SUB/AND/OR/LW/SW/BEQ/J/OTHER) and keeps saturating per-class and cycle counters.
- Pushes trace records {class, PC, write-data} into a parametrised FIFO drained through a valid/ready port.
- Sits beside the CPU top and is fed from the writeback/retire point.

---
 rtl/mips_mon_pkg.sv | 55 +++++
 rtl/mon_sync_fifo.sv | 58 +++++
 rtl/mips_retire_monitor.sv | 98 +++++++++
 tb/tb_mips_retire_monitor.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mon_pkg.sv
// rtl/mips_mon_pkg.sv - class codes, MIPS opcode/funct constants and decode helper
package mips_mon_pkg;

  localparam int NUM_CLS = 9;
  localparam int CLS_W   = 4;

  typedef enum logic [CLS_W-1:0] {
    CLS_ADD   = 4'd0,
    CLS_SUB   = 4'd1,
    CLS_AND   = 4'd2,
    CLS_OR    = 4'd3,
    CLS_LW    = 4'd4,
    CLS_SW    = 4'd5,
    CLS_BEQ   = 4'd6,
    CLS_J     = 4'd7,
    CLS_OTHER = 4'd8
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;

  localparam logic [3:0] SEL_CYCLE = 4'd9;
  localparam logic [3:0] SEL_DROP  = 4'd10;

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    cls_e c;
    c = CLS_OTHER;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  c = CLS_ADD;
          FN_SUB:  c = CLS_SUB;
          FN_AND:  c = CLS_AND;
          FN_OR:   c = CLS_OR;
          default: c = CLS_OTHER;
        endcase
      end
      OP_LW:   c = CLS_LW;
      OP_SW:   c = CLS_SW;
      OP_BEQ:  c = CLS_BEQ;
      OP_J:    c = CLS_J;
      default: c = CLS_OTHER;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mon_sync_fifo.sv
// rtl/mon_sync_fifo.sv - first-word-fall-through synchronous FIFO for trace records
module mon_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop frees the head slot first, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mips_retire_monitor.sv
// rtl/mips_retire_monitor.sv - retire classifier, saturating counters and trace FIFO
module mips_retire_monitor
  import mips_mon_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int REC_W = CLS_W + PC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_valid,
  input  logic [PC_W-1:0]   retire_pc,
  input  logic [5:0]        retire_opcode,
  input  logic [5:0]        retire_funct,
  input  logic [DATA_W-1:0] retire_wd,
  input  logic              trace_en,
  input  logic              freeze,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_data,
  input  logic [3:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_rdata,
  output logic              ovf,
  output logic [AW:0]       fifo_count
);

  logic [CNT_W-1:0] cls_cnt [NUM_CLS];
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] sel_val;
  cls_e             cls;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  assign cls  = classify(retire_opcode, retire_funct);
  assign push = retire_valid & trace_en;

  // Full implies non-empty, so out_ready alone decides whether a pop frees a slot.
  assign fifo_drop = push & ~clear & fifo_full & ~out_ready;

  always_comb begin
    sel_val = '0;
    if (cnt_sel < 4'(NUM_CLS)) sel_val = cls_cnt[cnt_sel];
    else if (cnt_sel == SEL_CYCLE) sel_val = cycle_cnt;
    else if (cnt_sel == SEL_DROP) sel_val = drop_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLS; i++) cls_cnt[i] <= '0;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      cnt_rdata <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CLS; i++) cls_cnt[i] <= '0;
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      cnt_rdata <= '0;
      ovf       <= 1'b0;
    end else begin
      if (!freeze) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
        if (retire_valid && cls_cnt[cls] != '1) cls_cnt[cls] <= cls_cnt[cls] + 1'b1;
      end
      if (fifo_drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      cnt_rdata <= sel_val;
    end
  end

  mon_sync_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (out_ready),
    .wdata ({cls, retire_pc, retire_wd}),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_mips_retire_monitor.sv
// tb/tb_mips_retire_monitor.sv - directed self-checking bench for mips_retire_monitor
module tb_mips_retire_monitor;
  import mips_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic [5:0]  retire_opcode;
  logic [5:0]  retire_funct;
  logic [31:0] retire_wd;
  logic        trace_en;
  logic        freeze;
  logic        clear;
  logic        out_ready;
  logic [3:0]  cnt_sel;

  logic        out_valid;
  logic [67:0] out_data;
  logic [31:0] cnt_rdata;
  logic        ovf;
  logic [4:0]  fifo_count;

  logic        s_out_valid;
  logic [67:0] s_out_data;
  logic [3:0]  s_cnt_rdata;
  logic        s_ovf;
  logic [4:0]  s_fifo_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_retire_monitor u_dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_opcode(retire_opcode), .retire_funct(retire_funct), .retire_wd(retire_wd),
    .trace_en(trace_en), .freeze(freeze), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata),
    .ovf(ovf), .fifo_count(fifo_count)
  );

  mips_retire_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_opcode(retire_opcode), .retire_funct(retire_funct), .retire_wd(retire_wd),
    .trace_en(trace_en), .freeze(freeze), .clear(clear), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .cnt_sel(cnt_sel), .cnt_rdata(s_cnt_rdata),
    .ovf(s_ovf), .fifo_count(s_fifo_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] pc, input logic [31:0] wd);
    retire_valid  = 1'b1;
    retire_opcode = op;
    retire_funct  = fn;
    retire_pc     = pc;
    retire_wd     = wd;
    step();
    retire_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; retire_valid = 1'b0; trace_en = 1'b0; freeze = 1'b0;
    clear = 1'b0; out_ready = 1'b0; cnt_sel = 4'd0;
    retire_pc = '0; retire_opcode = '0; retire_funct = '0; retire_wd = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; retire_valid = 1'b0; trace_en = 1'b0; freeze = 1'b0;
    clear = 1'b0; out_ready = 1'b0; cnt_sel = 4'd0;
    retire_pc = '0; retire_opcode = '0; retire_funct = '0; retire_wd = '0;
    #3;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 68'd0 || fifo_count !== 5'd0 || ovf !== 1'b0 || cnt_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b rdata=%0d expected all 0",
               out_valid, out_data, fifo_count, ovf, cnt_rdata);
    end
    n_vec++;
    if (s_out_valid !== 1'b0 || s_out_data !== 68'd0 || s_fifo_count !== 5'd0 || s_ovf !== 1'b0 || s_cnt_rdata !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state_sat: valid=%b count=%0d ovf=%b rdata=%0d expected all 0",
               s_out_valid, s_fifo_count, s_ovf, s_cnt_rdata);
    end
    step();
    rst = 1'b1;
    cnt_sel = SEL_CYCLE;
    for (int i = 0; i < 21; i++) step();
    n_vec++;
    if (cnt_rdata !== 32'd20) begin
      n_err++;
      $display("FAIL idle_cycles: got %0d expected 20", cnt_rdata);
    end
    for (int s = 0; s < NUM_CLS; s++) begin
      cnt_sel = 4'(s);
      step();
      n_vec++;
      if (cnt_rdata !== 32'd0) begin
        n_err++;
        $display("FAIL idle_cls_cnt[%0d]: got %0d expected 0", s, cnt_rdata);
      end
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_out_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_classify();
    int          exp_cnt [NUM_CLS] = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    logic [67:0] exp_rec [4];
    exp_rec[0] = {CLS_ADD,   32'h0, 32'h11};
    exp_rec[1] = {CLS_LW,    32'h4, 32'h55};
    exp_rec[2] = {CLS_BEQ,   32'h8, 32'h0};
    exp_rec[3] = {CLS_OTHER, 32'hC, 32'h0};
    do_reset();
    trace_en = 1'b1;
    retire(OP_RTYPE, FN_ADD, 32'h0, 32'h11);
    retire(OP_LW,    6'd0,   32'h4, 32'h55);
    retire(OP_BEQ,   6'd0,   32'h8, 32'h0);
    retire(6'd15,    6'd0,   32'hC, 32'h0);
    n_vec++;
    if (fifo_count !== 5'd4) begin
      n_err++;
      $display("FAIL classify_count: got %0d expected 4", fifo_count);
    end
    for (int s = 0; s < NUM_CLS; s++) begin
      cnt_sel = 4'(s);
      step();
      n_vec++;
      if (cnt_rdata !== 32'(exp_cnt[s])) begin
        n_err++;
        $display("FAIL classify_cls_cnt[%0d]: got %0d expected %0d", s, cnt_rdata, exp_cnt[s]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_rec[i]) begin
        n_err++;
        $display("FAIL classify_pop[%0d]: valid=%b data=%h expected 1 %h", i, out_valid, out_data, exp_rec[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 68'd0) begin
      n_err++;
      $display("FAIL classify_drained: valid=%b data=%h expected 0 0", out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [67:0] exp;
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 18; i++) retire(OP_RTYPE, FN_ADD, 32'(i * 4), 32'(i));
    n_vec++;
    if (fifo_count !== 5'd16 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: count=%0d ovf=%b expected 16 1", fifo_count, ovf);
    end
    cnt_sel = SEL_DROP;
    step();
    n_vec++;
    if (cnt_rdata !== 32'd2) begin
      n_err++;
      $display("FAIL ovf_drop_cnt: got %0d expected 2", cnt_rdata);
    end
    out_ready = 1'b1;
    retire(OP_RTYPE, FN_ADD, 32'h100, 32'h100);
    out_ready = 1'b0;
    step();
    n_vec++;
    if (fifo_count !== 5'd16 || cnt_rdata !== 32'd2) begin
      n_err++;
      $display("FAIL full_push_pop: count=%0d drop=%0d expected 16 2", fifo_count, cnt_rdata);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? {CLS_ADD, 32'((i + 1) * 4), 32'(i + 1)} : {CLS_ADD, 32'h100, 32'h100};
      n_vec++;
      if (out_data !== exp) begin
        n_err++;
        $display("FAIL ovf_drain[%0d]: got %h expected %h", i, out_data, exp);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    n_vec++;
    if (fifo_count !== 5'd0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: count=%0d ovf=%b expected 0 1", fifo_count, ovf);
    end
  endtask

  task automatic test_saturate_freeze();
    do_reset();
    for (int i = 0; i < 17; i++) retire(OP_RTYPE, FN_ADD, 32'h0, 32'h0);
    cnt_sel = 4'd0;
    step();
    n_vec++;
    if (s_cnt_rdata !== 4'd15) begin
      n_err++;
      $display("FAIL sat_cls_cnt: got %0d expected 15", s_cnt_rdata);
    end
    n_vec++;
    if (cnt_rdata !== 32'd17) begin
      n_err++;
      $display("FAIL wide_cls_cnt: got %0d expected 17", cnt_rdata);
    end
    clear = 1'b1;
    freeze = 1'b1;
    step();
    clear = 1'b0;
    cnt_sel = SEL_CYCLE;
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (cnt_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL freeze_cycle: got %0d expected 0", cnt_rdata);
    end
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (cnt_rdata !== 32'd3) begin
      n_err++;
      $display("FAIL unfreeze_cycle: got %0d expected 3", cnt_rdata);
    end
  endtask

  task automatic test_clear();
    logic [3:0] sels [4] = '{SEL_CYCLE, 4'd5, SEL_DROP, 4'd0};
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 17; i++) retire(OP_RTYPE, FN_ADD, 32'(i * 4), 32'h0);
    clear = 1'b1;
    cnt_sel = 4'd5;
    retire(OP_SW, 6'd0, 32'h200, 32'h0);
    clear = 1'b0;
    n_vec++;
    if (fifo_count !== 5'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || cnt_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL clear_state: count=%0d valid=%b ovf=%b rdata=%0d expected 0 0 0 0",
               fifo_count, out_valid, ovf, cnt_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      cnt_sel = sels[i];
      step();
      n_vec++;
      if (cnt_rdata !== 32'd0) begin
        n_err++;
        $display("FAIL clear_cnt[sel %0d]: got %0d expected 0", sels[i], cnt_rdata);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    trace_en = 1'b1;
    for (int i = 0; i < 7; i++) retire(OP_LW, 6'd0, 32'(i * 4), 32'(i));
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    n_vec++;
    if (fifo_count !== 5'd5 || out_data !== {CLS_LW, 32'h8, 32'h2}) begin
      n_err++;
      $display("FAIL mid_drain: count=%0d data=%h expected 5 %h", fifo_count, out_data, {CLS_LW, 32'h8, 32'h2});
    end
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd0 || out_data !== 68'd0 || cnt_rdata !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d data=%h rdata=%0d expected 0 0 0 0",
               out_valid, fifo_count, out_data, cnt_rdata);
    end
    step();
    out_ready = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_classify();
    test_overflow();
    test_saturate_freeze();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
